// File: rtl/mux2.sv
// Registered 8-function ALU/source selector: one result per clock, with carry/borrow and zero flags.
// Reset is synchronous and forces out=0, carry=0, zero=1.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;

  // Extra top bit of the widened sum is the carry; of the difference, the borrow.
  assign sum_w  = {1'b0, X} + {1'b0, Y};
  assign diff_w = {1'b0, X} - {1'b0, Y};

  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    case (sel)
      3'd0: out_d = X;
      3'd1: out_d = Y;
      3'd2: begin
        out_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
      end
      3'd3: begin
        out_d   = diff_w[WIDTH-1:0];
        carry_d = diff_w[WIDTH];
      end
      3'd4: out_d = X & Y;
      3'd5: out_d = X | Y;
      3'd6: out_d = X ^ Y;
      3'd7: out_d = ~X;
      default: out_d = '0;
    endcase
    if (rst) begin
      out_d   = '0;
      carry_d = 1'b0;
    end
    zero_d = (out_d == '0);
  end

  always_ff @(posedge clk) begin
    out_q   <= out_d;
    carry_q <= carry_d;
    zero_q  <= zero_d;
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_mux2.sv
// Directed bench for mux2: inputs driven on the falling edge, outputs checked 1ns after the rising edge.
module tb_mux2;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [2:0]       sel;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  int total = 0;
  int bad   = 0;

  mux2 #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .X    (X),
    .Y    (Y),
    .sel  (sel),
    .out  (out),
    .carry(carry),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check3(input string tag, input logic [WIDTH-1:0] e_out,
                        input logic e_carry, input logic e_zero);
    check({tag, ".out"},   32'(out),   32'(e_out));
    check({tag, ".carry"}, 32'(carry), 32'(e_carry));
    check({tag, ".zero"},  32'(zero),  32'(e_zero));
  endtask

  // Apply inputs on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic r, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic [2:0] s);
    @(negedge clk);
    rst = r; X = x; Y = y; sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; X = 8'h01; Y = 8'h00; sel = 3'd0;

    step(1'b1, 8'h01, 8'h00, 3'd0); check3("rst_edge1", 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h01, 8'h00, 3'd0); check3("rst_edge2", 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h01, 8'h00, 3'd0); check3("rst_release", 8'h01, 1'b0, 1'b0);

    step(1'b0, 8'h03, 8'h05, 3'd1); check3("sel1_y", 8'h05, 1'b0, 1'b0);
    step(1'b0, 8'h03, 8'h05, 3'd2); check3("add_3_5", 8'h08, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 8'h01, 3'd2); check3("add_wrap", 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'hFF, 8'hFF, 3'd2); check3("add_ff_ff", 8'hFE, 1'b1, 1'b0);
    step(1'b0, 8'h03, 8'h05, 3'd3); check3("sub_borrow", 8'hFE, 1'b1, 1'b0);
    step(1'b0, 8'h05, 8'h03, 3'd3); check3("sub_no_borrow", 8'h02, 1'b0, 1'b0);
    step(1'b0, 8'h5A, 8'h5A, 3'd3); check3("sub_equal", 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h01, 3'd3); check3("sub_0_1", 8'hFF, 1'b1, 1'b0);

    step(1'b0, 8'hF0, 8'h3C, 3'd4); check3("and", 8'h30, 1'b0, 1'b0);
    step(1'b0, 8'hF0, 8'h3C, 3'd5); check3("or",  8'hFC, 1'b0, 1'b0);
    step(1'b0, 8'hF0, 8'h3C, 3'd6); check3("xor", 8'hCC, 1'b0, 1'b0);
    step(1'b0, 8'hF0, 8'h3C, 3'd7); check3("not", 8'h0F, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 8'h00, 3'd7); check3("not_ff", 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h0F, 8'hF0, 3'd4); check3("and_zero", 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'hA5, 8'hA5, 3'd6); check3("xor_zero", 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0); check3("sel0_zero", 8'h00, 1'b0, 1'b1);

    // Mid-cycle glitch on X; registered outputs must not move between edges.
    step(1'b0, 8'h55, 8'h00, 3'd0); check3("hold_x55", 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    X = 8'hAA;
    #1 check3("glitch_mid_aa", 8'h55, 1'b0, 1'b0);
    #2 X = 8'h55;
    @(posedge clk); #1;
    check3("glitch_edge", 8'h55, 1'b0, 1'b0);
    @(posedge clk); #1;
    check3("held_const", 8'h55, 1'b0, 1'b0);

    // Input change between edges is invisible until the next edge.
    @(negedge clk);
    sel = 3'd7;
    #1 check3("sel_change_mid", 8'h55, 1'b0, 1'b0);
    @(posedge clk); #1;
    check3("sel_change_edge", 8'hAA, 1'b0, 1'b0);

    // rst pulse strictly between edges has no effect.
    @(negedge clk);
    rst = 1'b1;
    #1 check3("rst_mid_pulse", 8'hAA, 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check3("rst_mid_after", 8'hAA, 1'b0, 1'b0);

    // Addition stream with a one-edge reset in the middle.
    step(1'b0, 8'h10, 8'h20, 3'd2); check3("stream_a", 8'h30, 1'b0, 1'b0);
    step(1'b0, 8'h80, 8'h90, 3'd2); check3("stream_b", 8'h10, 1'b1, 1'b0);
    step(1'b1, 8'hF0, 8'h20, 3'd2); check3("stream_rst", 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h07, 8'h09, 3'd2); check3("stream_resume", 8'h10, 1'b0, 1'b0);
    step(1'b0, 8'hC8, 8'h64, 3'd2); check3("stream_c", 8'h2C, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux2.md
MUX2 -- requirements
Module: mux2

Interface
REQ-001 Parameter: WIDTH, default 8, data width of X, Y and out.
REQ-002 Port: clk  input  1  rising-edge clock; the single clock for the block.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: X  input  WIDTH  operand A.
REQ-005 Port: Y  input  WIDTH  operand B.
REQ-006 Port: sel  input  3  operation/source select.
REQ-007 Port: out  output  WIDTH  registered result.
REQ-008 Port: carry  output  1  registered carry/borrow flag.
REQ-009 Port: zero  output  1  registered flag, high when out is all zeros.

Function
REQ-010 X, Y and sel shall be sampled on every rising clk edge when rst is low; out, carry and zero shall update on that same edge (1-cycle latency, no handshake, new result every cycle).
REQ-011 sel=0: out shall be X; carry shall be 0.
REQ-012 sel=1: out shall be Y; carry shall be 0.
REQ-013 sel=2: out shall be (X+Y) mod 2^WIDTH; carry shall be bit WIDTH of the unsigned WIDTH+1-bit sum.
REQ-014 sel=3: out shall be (X-Y) mod 2^WIDTH; carry shall be 1 exactly when X<Y unsigned (borrow).
REQ-015 sel=4: out shall be X AND Y; carry shall be 0.
REQ-016 sel=5: out shall be X OR Y; carry shall be 0.
REQ-017 sel=6: out shall be X XOR Y; carry shall be 0.
REQ-018 sel=7: out shall be bitwise NOT X; carry shall be 0.
REQ-019 zero shall be 1 exactly when the value registered into out is 0, for every sel.
REQ-020 All operands shall be treated as unsigned; overflow shall wrap, never saturate.
REQ-021 Changes on X, Y or sel between clock edges shall have no effect on the outputs until the next rising edge.
REQ-022 With X, Y and sel held constant, the outputs shall hold the same values on every subsequent edge.

Reset
REQ-023 While rst is high at a rising edge, out shall become 0, carry 0 and zero 1, regardless of X, Y and sel.
REQ-024 rst shall have no effect between clock edges (synchronous only).
REQ-025 On the first rising edge with rst low, the outputs shall reflect the inputs sampled at that edge; there shall be no extra recovery cycles.
REQ-026 Asserting rst during operation shall override the selected operation on that edge.

Verification
REQ-027 rst=1 for 2 edges with X=1, Y=0, sel=0 -> out=0x00, carry=0, zero=1; after rst drops, next edge -> out=0x01, zero=0.
REQ-028 sel=1, X=3, Y=5 -> out=0x05 one edge later; then sel=2, X=3, Y=5 -> out=0x08, carry=0.
REQ-029 sel=2, X=0xFF, Y=0x01 -> out=0x00, carry=1, zero=1; sel=3, X=3, Y=5 -> out=0xFE, carry=1, zero=0.
REQ-030 sel=4/5/6/7 with X=0xF0, Y=0x3C -> out=0x30, 0xFC, 0xCC, 0x0F respectively; carry=0 in each case.
REQ-031 sel=0, X=0x55 held; toggle X to 0xAA mid-cycle and back to 0x55 before the edge -> out=0x55, with no glitch on the registered outputs.
REQ-032 rst=1 asserted for one edge during a stream of sel=2 additions -> out=0, carry=0, zero=1 on that edge; the stream resumes with correct sums on the next edge.
